// File: rtl/spi_luks.sv
// SPI master for an 8-bit serial light-sensor ADC: 16-clock read frame, sample on toMemory.
// Optional frame_err output and check logic enabled by `define SPI_LUKS_FRAME_CHECK_EN.
module spi_luks #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic       miso,
  output logic       sclk,
  output logic       ss,
  output logic       ready,
  output logic [7:0] toMemory
`ifdef SPI_LUKS_FRAME_CHECK_EN
  ,
  output logic       frame_err
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(2 * CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);

  // Only the low frame bits that something reads are kept; the first sample is never used.
`ifdef SPI_LUKS_FRAME_CHECK_EN
  localparam int SH_W = 15;
`else
  localparam int SH_W = 12;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        half_q, half_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              sclk_q, sclk_d;
  logic              ss_q, ss_d;
  logic              ready_q, ready_d;
  logic [7:0]        data_q, data_d;
`ifdef SPI_LUKS_FRAME_CHECK_EN
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    ready_d = 1'b0;
    data_d  = data_q;
`ifdef SPI_LUKS_FRAME_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = SHIFT;
          ss_d    = 1'b0;
          sclk_d  = 1'b1;
          div_d   = '0;
          half_d  = '0;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          half_d = half_q + 5'd1;
          if (sclk_q) begin
            sh_d = {sh_q[SH_W-2:0], miso};
          end
          // The 32nd toggle is the final rising edge; the shift register is already complete.
          if (half_q == 5'd31) begin
            state_d = DONE;
            ss_d    = 1'b1;
            ready_d = 1'b1;
            data_d  = sh_q[11:4];
`ifdef SPI_LUKS_FRAME_CHECK_EN
            err_d   = (|sh_q[14:12]) | (|sh_q[3:0]);
`endif
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d = GAP;
        gap_d   = '0;
      end
      GAP: begin
        // A still-held request restarts here directly so frames repeat at the minimum period.
        if (gap_q == GAP_LAST) begin
          if (valid) begin
            state_d = SHIFT;
            ss_d    = 1'b0;
            sclk_d  = 1'b1;
            div_d   = '0;
            half_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b1;
      ss_q    <= 1'b1;
      ready_q <= 1'b0;
      data_q  <= 8'h00;
`ifdef SPI_LUKS_FRAME_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      ready_q <= ready_d;
      data_q  <= data_d;
`ifdef SPI_LUKS_FRAME_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign sclk     = sclk_q;
  assign ss       = ss_q;
  assign ready    = ready_q;
  assign toMemory = data_q;
`ifdef SPI_LUKS_FRAME_CHECK_EN
  assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_spi_luks.sv
// Self-checking bench for spi_luks: CLK_DIV=2 and CLK_DIV=1 instances, sensor models, scoreboard.
module tb_spi_luks;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  localparam int LIMIT = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid2 = 1'b0, miso2 = 1'b0, sclk2, ss2, ready2;
  logic       valid1 = 1'b0, miso1 = 1'b0, sclk1, ss1, ready1;
  logic [7:0] data2, data1;
`ifdef SPI_LUKS_FRAME_CHECK_EN
  logic       frame_err2, frame_err1;
`endif

  int nchk = 0;
  int nerr = 0;

  exp_t        exp2_q[$];
  exp_t        exp1_q[$];
  logic [15:0] words2_q[$];
  logic [15:0] words1_q[$];
  logic [15:0] cur2, cur1;
  int          idx2 = 0, idx1 = 0;

  always #5 clk = ~clk;

  spi_luks #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .valid(valid2), .miso(miso2),
    .sclk(sclk2), .ss(ss2), .ready(ready2), .toMemory(data2)
`ifdef SPI_LUKS_FRAME_CHECK_EN
    , .frame_err(frame_err2)
`endif
  );

  spi_luks #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .valid(valid1), .miso(miso1),
    .sclk(sclk1), .ss(ss1), .ready(ready1), .toMemory(data1)
`ifdef SPI_LUKS_FRAME_CHECK_EN
    , .frame_err(frame_err1)
`endif
  );

  // Sensor models: present the MSB when selected, advance one bit on every sclk rise.
  always @(negedge ss2) begin
    if (words2_q.size() > 0) begin
      cur2 = words2_q.pop_front();
      idx2 = 15;
      miso2 = cur2[15];
    end
  end
  always @(posedge sclk2) begin
    if (!ss2 && idx2 > 0) begin
      idx2 = idx2 - 1;
      miso2 = cur2[idx2];
    end
  end
  always @(negedge ss1) begin
    if (words1_q.size() > 0) begin
      cur1 = words1_q.pop_front();
      idx1 = 15;
      miso1 = cur1[15];
    end
  end
  always @(posedge sclk1) begin
    if (!ss1 && idx1 > 0) begin
      idx1 = idx1 - 1;
      miso1 = cur1[idx1];
    end
  end

  function automatic logic cur_ss(input bit sel);
    return sel ? ss1 : ss2;
  endfunction

  function automatic logic cur_sclk(input bit sel);
    return sel ? sclk1 : sclk2;
  endfunction

  // Observes one frame from a negedge sample: ss-low length, sclk falls, then the ready window.
  task automatic measure(input bit sel, output int low_cyc, output int falls,
                         output logic rdy_first, output logic rdy_next, output logic sclk_end,
                         output logic [7:0] data, output logic err, output bit tmo);
    int   n;
    logic prev;
    n = 0; low_cyc = 0; falls = 0; prev = 1'b1; tmo = 1'b0;
    while (cur_ss(sel) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    while (!cur_ss(sel) && n < LIMIT) begin
      low_cyc++;
      if (prev && !cur_sclk(sel)) falls++;
      prev = cur_sclk(sel);
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) tmo = 1'b1;
    rdy_first = sel ? ready1 : ready2;
    sclk_end  = cur_sclk(sel);
    data      = sel ? data1 : data2;
`ifdef SPI_LUKS_FRAME_CHECK_EN
    err       = sel ? frame_err1 : frame_err2;
`else
    err       = 1'b0;
`endif
    @(negedge clk);
    rdy_next = sel ? ready1 : ready2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    nchk++; if (ss2 !== 1'b1) begin nerr++; $display("[TB] FAIL reset_ss: got %b want 1", ss2); end
    nchk++; if (sclk2 !== 1'b1) begin nerr++; $display("[TB] FAIL reset_sclk: got %b want 1", sclk2); end
    nchk++; if (ready2 !== 1'b0) begin nerr++; $display("[TB] FAIL reset_ready: got %b want 0", ready2); end
    nchk++; if (data2 !== 8'h00) begin nerr++; $display("[TB] FAIL reset_toMemory: got %h want 00", data2); end
    nchk++; if (ss1 !== 1'b1) begin nerr++; $display("[TB] FAIL reset_ss_div1: got %b want 1", ss1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame;
    int lo, fa; logic rf, rn, se, er; logic [7:0] d; bit tmo; exp_t e;
    words2_q.push_back(16'h0050);
    exp2_q.push_back('{data: 8'h05, err: 1'b0});
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    measure(1'b0, lo, fa, rf, rn, se, d, er, tmo);
    nchk++; if (tmo) begin nerr++; $display("[TB] FAIL single_timeout: got timeout want frame"); end
    nchk++; if (lo !== 64) begin nerr++; $display("[TB] FAIL single_ss_low: got %0d want 64", lo); end
    nchk++; if (fa !== 16) begin nerr++; $display("[TB] FAIL single_falls: got %0d want 16", fa); end
    nchk++; if (rf !== 1'b1) begin nerr++; $display("[TB] FAIL single_ready: got %b want 1", rf); end
    nchk++; if (rn !== 1'b0) begin nerr++; $display("[TB] FAIL single_ready_len: got %b want 0", rn); end
    nchk++; if (se !== 1'b1) begin nerr++; $display("[TB] FAIL single_sclk_end: got %b want 1", se); end
    e = exp2_q.pop_front();
    nchk++; if (d !== e.data) begin nerr++; $display("[TB] FAIL single_toMemory: got %h want %h", d, e.data); end
    repeat (10) @(negedge clk);
    nchk++; if (data2 !== e.data) begin nerr++; $display("[TB] FAIL single_hold: got %h want %h", data2, e.data); end
  endtask

  task automatic test_back_to_back;
    int lo, fa, gap, n, extra; logic rf, rn, se, er; logic [7:0] d; bit tmo; exp_t e;
    words2_q.push_back(16'h0FF0);
    words2_q.push_back(16'h0000);
    exp2_q.push_back('{data: 8'hFF, err: 1'b0});
    exp2_q.push_back('{data: 8'h00, err: 1'b0});
    valid2 = 1'b1;
    @(negedge clk);
    measure(1'b0, lo, fa, rf, rn, se, d, er, tmo);
    e = exp2_q.pop_front();
    nchk++; if (tmo || lo !== 64) begin nerr++; $display("[TB] FAIL b2b1_ss_low: got %0d tmo=%0d want 64", lo, tmo); end
    nchk++; if (fa !== 16) begin nerr++; $display("[TB] FAIL b2b1_falls: got %0d want 16", fa); end
    nchk++; if (rf !== 1'b1 || rn !== 1'b0) begin nerr++; $display("[TB] FAIL b2b1_ready: got %b%b want 10", rf, rn); end
    nchk++; if (d !== e.data) begin nerr++; $display("[TB] FAIL b2b1_toMemory: got %h want %h", d, e.data); end
    // DONE cycle plus the 4-cycle quiet gap; measure already saw two ss-high samples.
    gap = 2; n = 0;
    @(negedge clk);
    while (ss2 && n < LIMIT) begin
      gap++; n++;
      @(negedge clk);
    end
    nchk++; if (gap !== 5) begin nerr++; $display("[TB] FAIL b2b_gap: got %0d want 5", gap); end
    valid2 = 1'b0;
    measure(1'b0, lo, fa, rf, rn, se, d, er, tmo);
    e = exp2_q.pop_front();
    nchk++; if (tmo || lo !== 64) begin nerr++; $display("[TB] FAIL b2b2_ss_low: got %0d tmo=%0d want 64", lo, tmo); end
    nchk++; if (rf !== 1'b1 || rn !== 1'b0) begin nerr++; $display("[TB] FAIL b2b2_ready: got %b%b want 10", rf, rn); end
    nchk++; if (d !== e.data) begin nerr++; $display("[TB] FAIL b2b2_toMemory: got %h want %h", d, e.data); end
    extra = 0;
    repeat (80) begin
      if (!ss2) extra++;
      @(negedge clk);
    end
    nchk++; if (extra !== 0) begin nerr++; $display("[TB] FAIL b2b_no_third: got %0d low cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_frame;
    int fa, n, rdy; logic prev;
    words2_q.push_back(16'h0FF0);
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    fa = 0; n = 0; prev = 1'b1;
    while (fa < 8 && n < LIMIT) begin
      if (prev && !sclk2) fa++;
      prev = sclk2;
      if (fa < 8) @(negedge clk);
      n++;
    end
    nchk++; if (fa !== 8) begin nerr++; $display("[TB] FAIL mid_falls: got %0d want 8", fa); end
    rst = 1'b1;
    @(negedge clk);
    nchk++; if (ss2 !== 1'b1) begin nerr++; $display("[TB] FAIL mid_ss: got %b want 1", ss2); end
    nchk++; if (sclk2 !== 1'b1) begin nerr++; $display("[TB] FAIL mid_sclk: got %b want 1", sclk2); end
    nchk++; if (ready2 !== 1'b0) begin nerr++; $display("[TB] FAIL mid_ready: got %b want 0", ready2); end
    nchk++; if (data2 !== 8'h00) begin nerr++; $display("[TB] FAIL mid_toMemory: got %h want 00", data2); end
    rst = 1'b0;
    rdy = 0;
    repeat (80) begin
      @(negedge clk);
      if (ready2) rdy++;
    end
    nchk++; if (rdy !== 0) begin nerr++; $display("[TB] FAIL mid_no_ready: got %0d pulses want 0", rdy); end
  endtask

  task automatic test_div1;
    int lo, fa; logic rf, rn, se, er; logic [7:0] d; bit tmo; exp_t e;
    words1_q.push_back(16'h0A50);
    exp1_q.push_back('{data: 8'hA5, err: 1'b0});
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    measure(1'b1, lo, fa, rf, rn, se, d, er, tmo);
    e = exp1_q.pop_front();
    nchk++; if (tmo || lo !== 32) begin nerr++; $display("[TB] FAIL div1_ss_low: got %0d tmo=%0d want 32", lo, tmo); end
    nchk++; if (fa !== 16) begin nerr++; $display("[TB] FAIL div1_falls: got %0d want 16", fa); end
    nchk++; if (rf !== 1'b1 || rn !== 1'b0) begin nerr++; $display("[TB] FAIL div1_ready: got %b%b want 10", rf, rn); end
    nchk++; if (d !== e.data) begin nerr++; $display("[TB] FAIL div1_toMemory: got %h want %h", d, e.data); end
    repeat (5) @(negedge clk);
  endtask

`ifdef SPI_LUKS_FRAME_CHECK_EN
  task automatic test_frame_check;
    int lo, fa; logic rf, rn, se, er; logic [7:0] d; bit tmo; exp_t e;
    words2_q.push_back(16'h7050);
    words2_q.push_back(16'h0050);
    exp2_q.push_back('{data: 8'h05, err: 1'b1});
    exp2_q.push_back('{data: 8'h05, err: 1'b0});
    repeat (2) begin
      valid2 = 1'b1;
      @(negedge clk);
      valid2 = 1'b0;
      measure(1'b0, lo, fa, rf, rn, se, d, er, tmo);
      e = exp2_q.pop_front();
      nchk++; if (tmo || rf !== 1'b1) begin nerr++; $display("[TB] FAIL chk_ready: got %b tmo=%0d want 1", rf, tmo); end
      nchk++; if (d !== e.data) begin nerr++; $display("[TB] FAIL chk_toMemory: got %h want %h", d, e.data); end
      nchk++; if (er !== e.err) begin nerr++; $display("[TB] FAIL chk_frame_err: got %b want %b", er, e.err); end
      repeat (10) @(negedge clk);
      nchk++; if (frame_err2 !== e.err) begin nerr++; $display("[TB] FAIL chk_err_hold: got %b want %b", frame_err2, e.err); end
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_div1();
`ifdef SPI_LUKS_FRAME_CHECK_EN
    test_frame_check();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
